lbr_trace_unit: RTL and testbench

//  Next-generation last-branch-record unit. Captures taken control transfers (cond branch, JAL, JALR, return)

---
 rtl/lbr_trace_unit_if.sv | 51 +++++
 rtl/lbr_trace_unit.sv | 197 +++++++++++++++++++
 tb/tb_lbr_trace_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lbr_trace_unit_if.sv
// ---------------------------------------------------------------------------
// lbr_trace_unit_if
//   Bundles the branch-capture inputs and the memory-mapped register port of
//   the last-branch-record unit into a single interface.
//
//   Signals
//     stall        pipeline stall; branch inputs ignored while high
//     branch_valid control-transfer instruction resolves this cycle
//     branch_taken transfer taken
//     branch_type  00 cond, 01 JAL, 10 JALR, 11 return
//     PC_address   source PC
//     target_addr  resolved target
//     lbrReq       [1] read, [0] write; both high means write only
//     RW_address   register address
//     write_data   register write data
//     output_data  registered read data
//     lbr_irq      threshold interrupt (level)
//
//   Modports
//     master  drives the branch stream and register requests
//     slave   the trace unit itself
// ---------------------------------------------------------------------------
interface lbr_trace_unit_if #(
    parameter int ADDRESS_BITS = 20,
    parameter int DATA_WIDTH   = 32,
    parameter int AW           = 6
);
    logic                    stall;
    logic                    branch_valid;
    logic                    branch_taken;
    logic [1:0]              branch_type;
    logic [ADDRESS_BITS-1:0] PC_address;
    logic [ADDRESS_BITS-1:0] target_addr;
    logic [1:0]              lbrReq;
    logic [AW-1:0]           RW_address;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH-1:0]   output_data;
    logic                    lbr_irq;

    modport master (
        output stall, branch_valid, branch_taken, branch_type,
        output PC_address, target_addr, lbrReq, RW_address, write_data,
        input  output_data, lbr_irq
    );

    modport slave (
        input  stall, branch_valid, branch_taken, branch_type,
        input  PC_address, target_addr, lbrReq, RW_address, write_data,
        output output_data, lbr_irq
    );
endinterface

// File: rtl/lbr_trace_unit.sv
// ---------------------------------------------------------------------------
// lbr_trace_unit
//   Last-branch-record unit. Taken control transfers that pass the type
//   filter are captured in a two-step pipeline (latch, then commit) into a
//   circular buffer of {from, to, type} records. The buffer either
//   overwrites its oldest record when full or freezes, and a level interrupt
//   fires once the number of held records reaches a programmable threshold.
//
//   Ports
//     clock   rising-edge clock
//     reset   asynchronous, active-low reset
//     bus     lbr_trace_unit_if.slave: branch stream, register port,
//             read data and interrupt
//
//   Register map (RW_address[AW-1:AW-2])
//     00 control: 0 CTRL, 1 STATUS, anything else reads 0
//     01 FROM[i], 10 TO[i], 11 INFO[i]; i = 0 is the newest record
// ---------------------------------------------------------------------------
module lbr_trace_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDRESS_BITS = 20,
    parameter int LBR_SIZE     = 16
) (
    input  logic             clock,
    input  logic             reset,
    lbr_trace_unit_if.slave  bus
);
    localparam int IDX = $clog2(LBR_SIZE);
    localparam int AW  = IDX + 2;
    localparam int CW  = IDX + 1;
    localparam logic [CW-1:0] FULL = CW'(LBR_SIZE);

    // Control register fields
    logic            enable_q, freezeOnFull_q, irqEn_q;
    logic [3:0]      typeMask_q;
    logic [CW-1:0]   threshold_q;

    // Buffer bookkeeping
    logic [IDX-1:0]  tos_q, tos_d;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;
    logic            frozen_q, frozen_d;

    // Latched record waiting for its commit edge
    logic                    s1Valid_q;
    logic [ADDRESS_BITS-1:0] s1From_q, s1To_q;
    logic [1:0]              s1Type_q;

    logic [DATA_WIDTH-1:0]   outData_q, readData;
    logic                    irq_q, irq_d;

    // Record storage is deliberately left unreset; validity comes from count
    logic [ADDRESS_BITS-1:0] fromMem [LBR_SIZE];
    logic [ADDRESS_BITS-1:0] toMem   [LBR_SIZE];
    logic [1:0]              typeMem [LBR_SIZE];

    logic            qualify, wrEn, rdEn, ctrlWr, statusWr;
    logic            commitTry, dropFull, commit, full;
    logic [1:0]      region;
    logic [IDX-1:0]  lowAddr, physIdx, slot;
    logic            entryValid;
    logic            unusedWriteBits;

    assign region   = bus.RW_address[AW-1:AW-2];
    assign lowAddr  = bus.RW_address[IDX-1:0];
    assign wrEn     = bus.lbrReq[0];
    assign rdEn     = (bus.lbrReq == 2'b10);
    assign ctrlWr   = wrEn && region == 2'b00 && lowAddr == IDX'(0);
    assign statusWr = wrEn && region == 2'b00 && lowAddr == IDX'(1);

    assign qualify = bus.branch_valid & bus.branch_taken & ~bus.stall & enable_q
                   & typeMask_q[bus.branch_type] & ~frozen_q;

    // A latched record commits unless the buffer is frozen; a full buffer in
    // freeze mode drops it and freezes instead of overwriting.
    assign full      = (count_q == FULL);
    assign commitTry = s1Valid_q & ~frozen_q;
    assign dropFull  = commitTry & full & freezeOnFull_q;
    assign commit    = commitTry & ~dropFull;
    assign slot      = tos_q + 1'b1;

    assign physIdx    = tos_q - lowAddr;
    assign entryValid = ({1'b0, lowAddr} < count_q);

    assign irq_d = irqEn_q & (threshold_q != '0) & (count_q >= threshold_q);

    assign unusedWriteBits = ^bus.write_data;

    // Next-state for the buffer bookkeeping. A STATUS write clears the
    // counters but a commit landing on the same edge still counts as one.
    always_comb begin
        tos_d      = tos_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        frozen_d   = frozen_q;
        if (commit) begin
            tos_d = slot;
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
        if (dropFull) begin
            frozen_d = 1'b1;
        end
        if (statusWr) begin
            count_d    = commit ? CW'(1) : '0;
            overflow_d = 1'b0;
            frozen_d   = 1'b0;
        end
    end

    // Read mux; entries older than the held count read as zero.
    always_comb begin
        readData = '0;
        case (region)
            2'b00: begin
                if (lowAddr == IDX'(0)) begin
                    readData[0]       = enable_q;
                    readData[1]       = freezeOnFull_q;
                    readData[2]       = irqEn_q;
                    readData[7:4]     = typeMask_q;
                    readData[8 +: CW] = threshold_q;
                end else if (lowAddr == IDX'(1)) begin
                    readData[IDX-1:0] = tos_q;
                    readData[8 +: CW] = count_q;
                    readData[16]      = overflow_q;
                    readData[17]      = frozen_q;
                end
            end
            2'b01: if (entryValid) readData = DATA_WIDTH'(fromMem[physIdx]);
            2'b10: if (entryValid) readData = DATA_WIDTH'(toMem[physIdx]);
            default: begin
                if (entryValid) begin
                    readData[1:0]            = typeMem[physIdx];
                    readData[DATA_WIDTH-1]   = 1'b1;
                end
            end
        endcase
    end

    // Control, bookkeeping, capture latch, read data and interrupt
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enable_q       <= 1'b0;
            freezeOnFull_q <= 1'b0;
            irqEn_q        <= 1'b0;
            typeMask_q     <= '0;
            threshold_q    <= '0;
            tos_q          <= '0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            frozen_q       <= 1'b0;
            s1Valid_q      <= 1'b0;
            s1From_q       <= '0;
            s1To_q         <= '0;
            s1Type_q       <= '0;
            outData_q      <= '0;
            irq_q          <= 1'b0;
        end else begin
            if (ctrlWr) begin
                enable_q       <= bus.write_data[0];
                freezeOnFull_q <= bus.write_data[1];
                irqEn_q        <= bus.write_data[2];
                typeMask_q     <= bus.write_data[7:4];
                threshold_q    <= bus.write_data[8 +: CW];
            end
            tos_q      <= tos_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            frozen_q   <= frozen_d;
            s1Valid_q  <= qualify;
            if (qualify) begin
                s1From_q <= bus.PC_address;
                s1To_q   <= bus.target_addr;
                s1Type_q <= bus.branch_type;
            end
            if (rdEn) begin
                outData_q <= readData;
            end
            irq_q <= irq_d;
        end
    end

    // Record storage write port
    always_ff @(posedge clock) begin
        if (commit) begin
            fromMem[slot] <= s1From_q;
            toMem[slot]   <= s1To_q;
            typeMem[slot] <= s1Type_q;
        end
    end

    assign bus.output_data = outData_q;
    assign bus.lbr_irq     = irq_q;
endmodule

// File: tb/tb_lbr_trace_unit.sv
// ---------------------------------------------------------------------------
// tb_lbr_trace_unit
//   Self-checking bench for lbr_trace_unit. A behavioural model keeps the
//   held records in a queue (newest first) and advances once per clock,
//   alongside directed scenarios and randomized traffic.
// ---------------------------------------------------------------------------
module tb_lbr_trace_unit;
    localparam int DW = 32;
    localparam int AB = 20;
    localparam int N  = 16;
    localparam int AW = 6;

    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    lbr_trace_unit_if #(.ADDRESS_BITS(AB), .DATA_WIDTH(DW), .AW(AW)) bus ();

    lbr_trace_unit #(.DATA_WIDTH(DW), .ADDRESS_BITS(AB), .LBR_SIZE(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int assertCount = 0;
    int failCount   = 0;

    // Reference model state
    bit          mEn, mFrz, mIrqEn;
    bit [3:0]    mMask;
    int          mThr;
    int          mTos;
    bit          mOv, mFrozen, mIrq;
    logic [31:0] mOut;
    bit          pValid;
    logic [31:0] pFrom, pTo;
    int          pType;
    logic [31:0] qFrom[$];
    logic [31:0] qTo[$];
    int          qType[$];

    // Every comparison funnels through here
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic modelClear();
        mEn = 0; mFrz = 0; mIrqEn = 0; mMask = 0; mThr = 0;
        mTos = 0; mOv = 0; mFrozen = 0; mIrq = 0; mOut = 0;
        pValid = 0; pFrom = 0; pTo = 0; pType = 0;
        qFrom.delete(); qTo.delete(); qType.delete();
    endtask

    // What a register read should return given the model's current state
    function automatic logic [31:0] modelRead(input logic [5:0] a);
        int i;
        i = int'(a[3:0]);
        case (a[5:4])
            2'b00: begin
                if (i == 0)
                    return 32'(mEn) | (32'(mFrz) << 1) | (32'(mIrqEn) << 2)
                         | (32'(mMask) << 4) | (32'(mThr) << 8);
                if (i == 1)
                    return 32'(mTos) | (32'(qFrom.size()) << 8) | (32'(mOv) << 16)
                         | (32'(mFrozen) << 17);
                return 32'h0;
            end
            2'b01:   return (i < qFrom.size()) ? qFrom[i] : 32'h0;
            2'b10:   return (i < qTo.size()) ? qTo[i] : 32'h0;
            default: return (i < qType.size()) ? (32'h8000_0000 | 32'(qType[i])) : 32'h0;
        endcase
    endfunction

    task automatic setIdle();
        bus.stall = 0; bus.branch_valid = 0; bus.branch_taken = 0; bus.branch_type = 0;
        bus.PC_address = 0; bus.target_addr = 0; bus.lbrReq = 0;
        bus.RW_address = 0; bus.write_data = 0;
    endtask

    // One clock: advance the model with the inputs currently driven, take
    // the edge, then compare interrupt and read data.
    task automatic applyStimulus();
        logic [31:0] expRd, wd;
        bit          isRd, qual, irqNext, landed;
        int          sizeBefore;
        sizeBefore = qFrom.size();
        isRd       = (bus.lbrReq == 2'b10);
        expRd      = modelRead(bus.RW_address);
        qual       = bus.branch_valid && bus.branch_taken && !bus.stall && mEn
                     && mMask[bus.branch_type] && !mFrozen;
        irqNext    = mIrqEn && mThr != 0 && sizeBefore >= mThr;
        landed     = 0;
        if (pValid && !mFrozen) begin
            if (sizeBefore == N && mFrz) begin
                mFrozen = 1;
            end else begin
                qFrom.push_front(pFrom); qTo.push_front(pTo); qType.push_front(pType);
                if (qFrom.size() > N) begin
                    void'(qFrom.pop_back()); void'(qTo.pop_back()); void'(qType.pop_back());
                    mOv = 1;
                end
                mTos   = (mTos + 1) % N;
                landed = 1;
            end
        end
        if (bus.lbrReq[0] && bus.RW_address == 6'h01) begin
            while (qFrom.size() > (landed ? 1 : 0)) begin
                void'(qFrom.pop_back()); void'(qTo.pop_back()); void'(qType.pop_back());
            end
            mOv = 0;
            mFrozen = 0;
        end
        if (bus.lbrReq[0] && bus.RW_address == 6'h00) begin
            wd     = bus.write_data;
            mEn    = wd[0];
            mFrz   = wd[1];
            mIrqEn = wd[2];
            mMask  = wd[7:4];
            mThr   = int'(wd[12:8]);
        end
        pValid = qual;
        if (qual) begin
            pFrom = 32'(bus.PC_address);
            pTo   = 32'(bus.target_addr);
            pType = int'(bus.branch_type);
        end
        mIrq = irqNext;
        if (isRd) mOut = expRd;
        @(posedge clock);
        #1;
        checkOutput("irq", {31'b0, bus.lbr_irq}, {31'b0, mIrq});
        checkOutput(isRd ? "read" : "hold", bus.output_data, mOut);
    endtask

    task automatic driveBranch(input logic [1:0] t, input bit taken,
                               input logic [19:0] pc, input logic [19:0] tgt);
        bus.branch_valid = 1; bus.branch_taken = taken; bus.branch_type = t;
        bus.PC_address = pc; bus.target_addr = tgt;
        applyStimulus();
        bus.branch_valid = 0; bus.branch_taken = 0;
    endtask

    task automatic readReg(input logic [5:0] a);
        bus.lbrReq = 2'b10; bus.RW_address = a;
        applyStimulus();
        bus.lbrReq = 2'b00;
    endtask

    task automatic writeReg(input logic [5:0] a, input logic [31:0] d);
        bus.lbrReq = 2'b01; bus.RW_address = a; bus.write_data = d;
        applyStimulus();
        bus.lbrReq = 2'b00; bus.write_data = 0;
    endtask

    task automatic doReset();
        setIdle();
        @(negedge clock);
        reset = 0;
        modelClear();
        @(negedge clock);
        reset = 1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] ctl;
        int r;
        setIdle();
        modelClear();
        reset = 0;
        #12;
        reset = 1;
        @(posedge clock);
        #1;
        checkOutput("rst_out", bus.output_data, 32'h0);
        readReg(6'h00); checkOutput("rst_ctrl", bus.output_data, 32'h0);
        readReg(6'h01); checkOutput("rst_status", bus.output_data, 32'h0);

        // Single JAL capture with minimum read latency
        writeReg(6'h00, 32'h0F1);
        driveBranch(2'b01, 1, 20'h100, 20'h200);
        setIdle(); applyStimulus();
        readReg(6'h10); checkOutput("t1_from", bus.output_data, 32'h100);
        readReg(6'h20); checkOutput("t1_to", bus.output_data, 32'h200);
        readReg(6'h30); checkOutput("t1_info", bus.output_data, 32'h8000_0001);
        readReg(6'h01); checkOutput("t1_status", bus.output_data, 32'h101);
        readReg(6'h11); checkOutput("t1_older", bus.output_data, 32'h0);

        // Type mask: only conditional branches
        doReset();
        writeReg(6'h00, 32'h011);
        driveBranch(2'b01, 1, 20'h10, 20'h20);
        driveBranch(2'b10, 1, 20'h14, 20'h24);
        driveBranch(2'b00, 0, 20'h18, 20'h28);
        driveBranch(2'b00, 1, 20'h40, 20'h80);
        applyStimulus();
        readReg(6'h01); checkOutput("t2_count", (bus.output_data >> 8) & 32'h1F, 32'h1);
        readReg(6'h10); checkOutput("t2_from", bus.output_data, 32'h40);

        // Overwrite oldest on wrap
        doReset();
        writeReg(6'h00, 32'h0F1);
        for (int k = 0; k < 18; k++) driveBranch(2'(k), 1, 20'(32'h1000 + k * 4), 20'(32'h8000 + k));
        applyStimulus();
        readReg(6'h01); checkOutput("t3_status", bus.output_data, 32'h0001_1002);
        readReg(6'h1F); checkOutput("t3_from15", bus.output_data, 32'h1008);

        // Freeze on full
        doReset();
        writeReg(6'h00, 32'h0F3);
        for (int k = 0; k < 17; k++) driveBranch(2'(k), 1, 20'(32'h2000 + k * 4), 20'(32'h9000 + k));
        applyStimulus(); applyStimulus();
        driveBranch(2'b00, 1, 20'h3333, 20'h4444);
        applyStimulus();
        readReg(6'h01); checkOutput("t4_status", bus.output_data, 32'h0002_1000);
        readReg(6'h10); checkOutput("t4_from0", bus.output_data, 32'h203C);
        writeReg(6'h01, 32'h0);
        readReg(6'h01); checkOutput("t4_cleared", bus.output_data, 32'h0);

        // Threshold interrupt
        doReset();
        writeReg(6'h00, 32'h4F5);
        for (int k = 0; k < 4; k++) driveBranch(2'b11, 1, 20'(32'h500 + k), 20'(32'h600 + k));
        applyStimulus(); checkOutput("t5_irq_low", {31'b0, bus.lbr_irq}, 32'h0);
        applyStimulus(); checkOutput("t5_irq_high", {31'b0, bus.lbr_irq}, 32'h1);
        writeReg(6'h01, 32'h0); checkOutput("t5_irq_lag", {31'b0, bus.lbr_irq}, 32'h1);
        applyStimulus(); checkOutput("t5_irq_clr", {31'b0, bus.lbr_irq}, 32'h0);

        // Reset between latch and commit
        writeReg(6'h00, 32'h1F5);
        driveBranch(2'b01, 1, 20'h700, 20'h800);
        applyStimulus(); applyStimulus();
        readReg(6'h00);
        driveBranch(2'b01, 1, 20'h704, 20'h804);
        #3;
        reset = 0;
        modelClear();
        #1;
        checkOutput("t6_out", bus.output_data, 32'h0);
        checkOutput("t6_irq", {31'b0, bus.lbr_irq}, 32'h0);
        @(negedge clock); @(negedge clock);
        reset = 1;
        @(posedge clock); #1;
        setIdle(); applyStimulus(); applyStimulus();
        readReg(6'h01); checkOutput("t6_status", bus.output_data, 32'h0);
        readReg(6'h10); checkOutput("t6_from0", bus.output_data, 32'h0);

        // Randomized traffic under several configurations
        for (int cfg = 0; cfg < 4; cfg++) begin
            doReset();
            ctl = 32'h5 | (32'($urandom_range(0, 1)) << 1) | (32'($urandom_range(1, 15)) << 4)
                | (32'($urandom_range(0, 16)) << 8);
            writeReg(6'h00, ctl);
            for (int c = 0; c < 250; c++) begin
                bus.branch_valid = ($urandom_range(0, 9) < 6);
                bus.branch_taken = ($urandom_range(0, 3) != 0);
                bus.stall        = ($urandom_range(0, 7) == 0);
                bus.branch_type  = 2'($urandom_range(0, 3));
                bus.PC_address   = 20'($urandom);
                bus.target_addr  = 20'($urandom);
                r = $urandom_range(0, 99);
                bus.write_data = $urandom;
                if (r < 40) begin
                    bus.lbrReq = 2'b10; bus.RW_address = 6'($urandom);
                end else if (r < 45) begin
                    bus.lbrReq = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b11;
                    bus.RW_address = 6'h01;
                end else if (r < 47) begin
                    bus.lbrReq = 2'b01; bus.RW_address = 6'h00;
                    bus.write_data = 32'h5 | (32'($urandom_range(0, 1)) << 1)
                                   | (32'($urandom_range(0, 15)) << 4)
                                   | (32'($urandom_range(0, 16)) << 8);
                end else if (r < 50) begin
                    bus.lbrReq = 2'b01; bus.RW_address = 6'($urandom_range(2, 63));
                end else begin
                    bus.lbrReq = 2'b00;
                end
                applyStimulus();
            end
            setIdle();
            applyStimulus();
            for (int i = 0; i < 64; i++) readReg(6'(i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
